// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: active-low patterns, bit6=a .. bit0=g.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001111;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0000100;
  localparam seg_t SEG_DASH  = 7'b1111110;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Producer-facing bus of seg_scan_driver. Optional duty input under SEG_SCAN_DIM_EN.
interface seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  import seg_pkg::*;

  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic                  enable;
  logic                  load;
  logic [IDX_W-1:0]      load_idx;
  seg_t                  load_seg;
  logic                  swap_req;
  logic                  swap_ack;
  logic                  frame_done;
  seg_t                  seg_n;
  logic [NUM_DIGITS-1:0] an_n;
`ifdef SEG_SCAN_DIM_EN
  logic [3:0]            duty;
`endif

  modport master (
`ifdef SEG_SCAN_DIM_EN
    output duty,
`endif
    output enable, load, load_idx, load_seg, swap_req,
    input  swap_ack, frame_done, seg_n, an_n
  );

  modport slave (
`ifdef SEG_SCAN_DIM_EN
    input  duty,
`endif
    input  enable, load, load_idx, load_seg, swap_req,
    output swap_ack, frame_done, seg_n, an_n
  );

endinterface

// File: rtl/seg_scan_timebase.sv
// Slot/digit scan counters; enable=0 parks the scan at digit 0, slot 0.
module seg_scan_timebase #(
  parameter int NUM_DIGITS    = 4,
  parameter int PRESCALE_LOG2 = 16,
  localparam int DIG_W        = $clog2(NUM_DIGITS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  output logic                     boundary,
  output logic [PRESCALE_LOG2-1:0] slot_cnt,
  output logic [DIG_W-1:0]         digit
);

  localparam logic [PRESCALE_LOG2-1:0] SLOT_ONE = PRESCALE_LOG2'(1);
  localparam logic [DIG_W-1:0]         DIG_ONE  = DIG_W'(1);
  localparam logic [DIG_W-1:0]         DIG_LAST = DIG_W'(NUM_DIGITS - 1);

  logic [PRESCALE_LOG2-1:0] slot_cnt_d, slot_cnt_q;
  logic [DIG_W-1:0]         digit_d, digit_q;

  always_comb begin
    slot_cnt_d = slot_cnt_q + SLOT_ONE;
    digit_d    = digit_q;
    if (&slot_cnt_q)
      digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + DIG_ONE;
    if (!enable) begin
      slot_cnt_d = '0;
      digit_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt_q <= '0;
      digit_q    <= '0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      digit_q    <= digit_d;
    end
  end

  assign boundary = (slot_cnt_q == '0) && (digit_q == '0);
  assign slot_cnt = slot_cnt_q;
  assign digit    = digit_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Double-buffered multiplexed common-anode 7-seg driver with anode dead-time.
// Build with SEG_SCAN_DIM_EN to add the bus.duty brightness control.
module seg_scan_driver #(
  parameter int NUM_DIGITS    = 4,
  parameter int PRESCALE_LOG2 = 16,
  parameter int DEADTIME      = 64
) (
  input  logic             clk,
  input  logic             reset,
  seg_scan_driver_if.slave bus
);
  import seg_pkg::*;

  localparam int DIG_W = $clog2(NUM_DIGITS);
  localparam logic [PRESCALE_LOG2-1:0] DEAD_CNT = PRESCALE_LOG2'(DEADTIME);

  logic                     boundary;
  logic [PRESCALE_LOG2-1:0] slot_cnt;
  logic [DIG_W-1:0]         digit;

  logic [NUM_DIGITS-1:0][6:0] front_d, front_q;
  logic [NUM_DIGITS-1:0][6:0] back_d, back_q;
  logic                       pending_d, pending_q;
  seg_t                       seg_n_d, seg_n_q;
  logic [NUM_DIGITS-1:0]      an_n_d, an_n_q;
  logic                       frame_done_d, frame_done_q;
  logic                       swap_ack_d, swap_ack_q;
  logic                       commit;
  logic                       dim_ok;
  logic                       anode_on;

  seg_scan_timebase #(
    .NUM_DIGITS    (NUM_DIGITS),
    .PRESCALE_LOG2 (PRESCALE_LOG2)
  ) u_timebase (
    .clk      (clk),
    .reset    (reset),
    .enable   (bus.enable),
    .boundary (boundary),
    .slot_cnt (slot_cnt),
    .digit    (digit)
  );

`ifdef SEG_SCAN_DIM_EN
  // PWM inside the slot: the top 4 slot bits are the phase compared against duty.
  assign dim_ok = (slot_cnt[PRESCALE_LOG2-1 -: 4] <= bus.duty);
`else
  assign dim_ok = 1'b1;
`endif

  assign anode_on = bus.enable && (slot_cnt >= DEAD_CNT) && dim_ok;

  always_comb begin
    // While disabled nothing is on screen, so a commit cannot tear.
    commit    = (boundary || !bus.enable) && (pending_q || bus.swap_req);
    pending_d = !commit && (pending_q || bus.swap_req);

    // Commit copies back_q, i.e. the value before any same-cycle load.
    front_d = commit ? back_q : front_q;
    back_d  = back_q;
    if (bus.load && (int'(bus.load_idx) < NUM_DIGITS))
      back_d[bus.load_idx] = bus.load_seg;

    an_n_d  = '1;
    seg_n_d = SEG_BLANK;
    if (anode_on) begin
      an_n_d[digit] = 1'b0;
      seg_n_d       = front_q[digit];
    end

    frame_done_d = bus.enable && boundary;
    swap_ack_d   = commit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      front_q      <= {NUM_DIGITS{SEG_BLANK}};
      back_q       <= {NUM_DIGITS{SEG_BLANK}};
      pending_q    <= 1'b0;
      seg_n_q      <= SEG_BLANK;
      an_n_q       <= '1;
      frame_done_q <= 1'b0;
      swap_ack_q   <= 1'b0;
    end else begin
      front_q      <= front_d;
      back_q       <= back_d;
      pending_q    <= pending_d;
      seg_n_q      <= seg_n_d;
      an_n_q       <= an_n_d;
      frame_done_q <= frame_done_d;
      swap_ack_q   <= swap_ack_d;
    end
  end

  assign bus.seg_n      = seg_n_q;
  assign bus.an_n       = an_n_q;
  assign bus.frame_done = frame_done_q;
  assign bus.swap_ack   = swap_ack_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (NUM_DIGITS=4, PRESCALE_LOG2=4, DEADTIME=2) against a
// scan-position reference model; optional SEG_SCAN_DIM_EN scenario.
module tb_seg_scan_driver;
  import seg_pkg::*;

  localparam int N = 4, P = 4, DT = 2;
  localparam int SLOT = 1 << P, FRAME = N * SLOT;
  localparam int VW = 7 + N + 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg_scan_driver_if #(.NUM_DIGITS(N)) bus();

  seg_scan_driver #(.NUM_DIGITS(N), .PRESCALE_LOG2(P), .DEADTIME(DT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0, bad = 0;

  // Reference model: t is the scan position (cycles since the scan last restarted).
  seg_t m_front[N], m_back[N];
  bit   m_pend;
  int   t;
  logic [VW-1:0] exp_v;
  localparam logic [VW-1:0] RST_V = {SEG_BLANK, {N{1'b1}}, 1'b0, 1'b0};

  function automatic logic [VW-1:0] obs();
    return {bus.seg_n, bus.an_n, bus.frame_done, bus.swap_ack};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_front[i] = SEG_BLANK; m_back[i] = SEG_BLANK; end
    m_pend = 0;
    t = 0;
  endtask

  // Predict the registered outputs for the coming edge, advance one clock,
  // drop the single-cycle strobes and return at the following negedge.
  task automatic tick();
    int slot, dig, duty_v;
    bit on, bnd, commit;
    seg_t e_seg;
    logic [N-1:0] e_an;
`ifdef SEG_SCAN_DIM_EN
    duty_v = int'(bus.duty);
`else
    duty_v = 15;
`endif
    slot = t % SLOT;
    dig  = (t / SLOT) % N;
    bnd  = (t % FRAME) == 0;
    on   = bus.enable && slot >= DT && (slot >> (P - 4)) <= duty_v;
    e_an = '1;
    e_seg = SEG_BLANK;
    if (on) begin e_an[dig] = 1'b0; e_seg = m_front[dig]; end
    commit = (!bus.enable || bnd) && (m_pend || bus.swap_req);
    exp_v = {e_seg, e_an, bus.enable && bnd, commit};
    if (commit) begin m_front = m_back; m_pend = 0; end
    else if (bus.swap_req) m_pend = 1;
    if (bus.load && int'(bus.load_idx) < N) m_back[bus.load_idx] = bus.load_seg;
    t = bus.enable ? t + 1 : 0;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    bus.swap_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.enable = 1'b1; bus.load = 1'b0; bus.load_idx = '0; bus.load_seg = '0; bus.swap_req = 1'b0;
`ifdef SEG_SCAN_DIM_EN
    bus.duty = 4'd15;
`endif
    model_reset();
    @(negedge clk); @(negedge clk);
    total++;
    if (obs() !== RST_V) begin bad++; $display("FAIL reset got=%h want=%h", obs(), RST_V); end
    reset = 1'b0;
  endtask

  task automatic test_idle();
    int on0 = 0, fd = 0;
    repeat (2 * FRAME) begin
      tick();
      total++;
      if (obs() !== exp_v) begin bad++; $display("FAIL idle t=%0d got=%h want=%h", t, obs(), exp_v); end
      if (bus.an_n == 4'b1110) on0++;
      if (bus.frame_done) fd++;
    end
    total++;
    if (on0 != 28) begin bad++; $display("FAIL idle_on_cycles got=%0d want=28", on0); end
    total++;
    if (fd != 2) begin bad++; $display("FAIL idle_frame_done got=%0d want=2", fd); end
  endtask

  task automatic test_load_swap();
    seg_t pat[N] = '{SEG_0, SEG_1, SEG_2, SEG_3};
    bit acked = 0;
    for (int i = 0; i < N; i++) begin
      bus.load = 1'b1; bus.load_idx = 2'(i); bus.load_seg = pat[i];
      tick();
      total++;
      if (obs() !== exp_v) begin bad++; $display("FAIL load t=%0d got=%h want=%h", t, obs(), exp_v); end
    end
    repeat (20) begin
      tick();
      total++;
      if (bus.seg_n !== SEG_BLANK) begin bad++; $display("FAIL no_swap_blank got=%h want=7f", bus.seg_n); end
    end
    bus.swap_req = 1'b1;
    repeat (2 * FRAME) begin
      tick();
      total++;
      if (obs() !== exp_v) begin bad++; $display("FAIL swap t=%0d got=%h want=%h", t, obs(), exp_v); end
      if (bus.swap_ack) acked = 1;
      for (int d = 0; d < N; d++)
        if (acked && bus.an_n == ~(4'(1) << d)) begin
          total++;
          if (bus.seg_n !== pat[d]) begin bad++; $display("FAIL swap_digit%0d got=%h want=%h", d, bus.seg_n, pat[d]); end
        end
    end
    total++;
    if (!acked) begin bad++; $display("FAIL swap_ack got=0 want=1 (timeout)"); end
  endtask

  task automatic test_tear_free();
    int guard = 0;
    bit acked = 0;
    while (t % FRAME != 2 * SLOT + 5 && guard < 2 * FRAME) begin tick(); guard++; end
    bus.load = 1'b1; bus.load_idx = 2'd1; bus.load_seg = SEG_DASH;
    repeat (FRAME + 40) begin
      tick();
      total++;
      if (obs() !== exp_v) begin bad++; $display("FAIL tear t=%0d got=%h want=%h", t, obs(), exp_v); end
      if (bus.an_n == 4'b1101 && bus.seg_n !== SEG_1) begin
        bad++; $display("FAIL tear_hold got=%h want=%h", bus.seg_n, SEG_1);
      end
    end
    bus.swap_req = 1'b1;
    repeat (2 * FRAME) begin
      tick();
      total++;
      if (obs() !== exp_v) begin bad++; $display("FAIL tear_swap t=%0d got=%h want=%h", t, obs(), exp_v); end
      if (bus.swap_ack) acked = 1;
      if (bus.an_n == 4'b1101) begin
        total++;
        if (bus.seg_n !== (acked ? SEG_DASH : SEG_1)) begin
          bad++; $display("FAIL tear_new got=%h want=%h", bus.seg_n, acked ? SEG_DASH : SEG_1);
        end
      end
    end
  endtask

  task automatic test_collision();
    int guard = 0;
    bit acked = 0;
    while (t % FRAME != 0 && guard < 2 * FRAME) begin tick(); guard++; end
    bus.load = 1'b1; bus.load_idx = 2'd0; bus.load_seg = SEG_5; bus.swap_req = 1'b1;
    tick();
    total++;
    if (bus.swap_ack !== 1'b1) begin bad++; $display("FAIL coll_ack got=%b want=1", bus.swap_ack); end
    repeat (FRAME - 1) begin
      tick();
      if (bus.an_n == 4'b1110) begin
        total++;
        if (bus.seg_n !== SEG_0) begin bad++; $display("FAIL coll_old got=%h want=%h", bus.seg_n, SEG_0); end
      end
    end
    bus.swap_req = 1'b1;
    repeat (2 * FRAME) begin
      tick();
      total++;
      if (obs() !== exp_v) begin bad++; $display("FAIL coll t=%0d got=%h want=%h", t, obs(), exp_v); end
      if (bus.swap_ack) acked = 1;
      if (acked && bus.an_n == 4'b1110 && bus.seg_n !== SEG_5) begin
        bad++; $display("FAIL coll_new got=%h want=%h", bus.seg_n, SEG_5);
      end
    end
  endtask

  task automatic test_enable();
    logic [N-1:0] want_an[3] = '{4'b1111, 4'b1111, 4'b1110};
    repeat (SLOT + 7) tick();
    bus.load = 1'b1; bus.load_idx = 2'd3; bus.load_seg = SEG_9; bus.swap_req = 1'b1;
    tick();
    bus.enable = 1'b0;
    tick();
    total++;
    if (bus.an_n !== 4'b1111 || bus.swap_ack !== 1'b1) begin
      bad++; $display("FAIL disable got an=%b ack=%b want an=1111 ack=1", bus.an_n, bus.swap_ack);
    end
    repeat (5) begin
      tick();
      total++;
      if (obs() !== exp_v) begin bad++; $display("FAIL disabled got=%h want=%h", obs(), exp_v); end
    end
    bus.enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus.an_n !== want_an[i] || bus.frame_done !== (i == 0)) begin
        bad++; $display("FAIL reenable%0d got an=%b fd=%b want an=%b fd=%b", i, bus.an_n, bus.frame_done, want_an[i], i == 0);
      end
    end
    repeat (FRAME) begin
      tick();
      total++;
      if (obs() !== exp_v) begin bad++; $display("FAIL reenable t=%0d got=%h want=%h", t, obs(), exp_v); end
    end
  endtask

  task automatic test_random();
    repeat (1500) begin
      bus.load     = ($urandom_range(3) == 0);
      bus.load_idx = 2'($urandom_range(N - 1));
      bus.load_seg = 7'($urandom);
      bus.swap_req = ($urandom_range(15) == 0);
      if ($urandom_range(60) == 0) bus.enable = ~bus.enable;
`ifdef SEG_SCAN_DIM_EN
      if ($urandom_range(40) == 0) bus.duty = 4'($urandom);
`endif
      tick();
      total++;
      if (obs() !== exp_v) begin bad++; $display("FAIL random t=%0d got=%h want=%h", t, obs(), exp_v); end
    end
    bus.enable = 1'b1;
`ifdef SEG_SCAN_DIM_EN
    bus.duty = 4'd15;
`endif
    tick();
  endtask

`ifdef SEG_SCAN_DIM_EN
  task automatic test_dim();
    logic [3:0] duties[3] = '{4'd7, 4'd0, 4'd15};
    int want[3] = '{6, 0, 14};
    int on0;
    foreach (duties[k]) begin
      bus.duty = duties[k];
      while (t % FRAME != 0) tick();
      on0 = 0;
      repeat (FRAME) begin
        tick();
        total++;
        if (obs() !== exp_v) begin bad++; $display("FAIL dim t=%0d got=%h want=%h", t, obs(), exp_v); end
        if (bus.an_n == 4'b1110) on0++;
      end
      total++;
      if (on0 != want[k]) begin bad++; $display("FAIL dim_duty%0d got=%0d want=%0d", duties[k], on0, want[k]); end
    end
  endtask
`endif

  task automatic test_reset_mid();
    repeat (SLOT + 6) tick();
    #2 reset = 1'b1;
    #1;
    total++;
    if (obs() !== RST_V) begin bad++; $display("FAIL async_reset got=%h want=%h", obs(), RST_V); end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.swap_req = 1'b1;
    repeat (2 * FRAME) begin
      tick();
      total++;
      if (obs() !== exp_v) begin bad++; $display("FAIL post_reset t=%0d got=%h want=%h", t, obs(), exp_v); end
      if (bus.seg_n !== SEG_BLANK) begin bad++; $display("FAIL buffers_lost got=%h want=7f", bus.seg_n); end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_load_swap();
    test_tear_free();
    test_collision();
    test_enable();
`ifdef SEG_SCAN_DIM_EN
    test_dim();
`endif
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
